// File: rtl/aes_pkg.sv
// Shared AES byte-level definitions: byte type, field constants and the forward S-box lookup.
// The S-box is a constant 256-entry table, reusable by the round datapath and key expansion.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam logic [8:0] AES_POLY     = 9'h11B;
  localparam aes_byte_t  AES_AFFINE_C = 8'h63;

  // Row r holds S(16*r + c) for c = 0..15; index 0 is the most significant byte.
  localparam logic [0:255][7:0] AES_SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_byte_t aes_sbox_f(input aes_byte_t b);
    return AES_SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box for one byte lane with a single register stage and valid qualifier.
// The output byte only updates on accepted inputs, so X on an idle input never reaches it.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       out_valid
);

  aes_byte_t sub_byte;

  always_comb begin
    sub_byte = aes_sbox_f(in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sub_byte;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox: directed steps plus a random stream, checked against
// an S-box model built from GF(2^8) arithmetic and the affine map.
module tb_aes_sbox;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in;
  logic [7:0] out;
  logic       out_valid;

  int passed = 0;
  int total  = 0;

  aes_sbox dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [8:0] poly = AES_POLY;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ poly[7:0]) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] v = ginv(x);
    logic [7:0] c = AES_AFFINE_C;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] known_in  [8] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'h7F, 8'h80, 8'hC9, 8'hFF};
  logic [7:0] known_out [8] = '{8'h63, 8'h7C, 8'hCA, 8'hED, 8'hD2, 8'hCD, 8'hDD, 8'h16};
  logic [7:0] sweep_out [256];
  bit         seen [256];
  int         distinct;
  int         fixed_pts;
  logic [7:0] exp_out;
  logic       exp_vld;
  logic [7:0] d;
  logic       v;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in       = 8'h53;
    #1;
    chk("reset_out_t0", out, 8'h00);
    chk("reset_vld_t0", {7'b0, out_valid}, 8'h00);
    repeat (3) begin
      tick();
      chk("reset_out", out, 8'h00);
      chk("reset_vld", {7'b0, out_valid}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("release_out", out, 8'hED);
    chk("release_vld", {7'b0, out_valid}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      in = known_in[i];
      tick();
      chk($sformatf("known_%02h", known_in[i]), out, known_out[i]);
      chk($sformatf("known_model_%02h", known_in[i]), out, ref_sbox(known_in[i]));
      chk("known_vld", {7'b0, out_valid}, 8'h01);
    end

    for (int i = 0; i < 256; i++) begin
      in = 8'(i);
      tick();
      sweep_out[i] = out;
      chk($sformatf("sweep_%02h", i), out, ref_sbox(8'(i)));
      chk("sweep_vld", {7'b0, out_valid}, 8'h01);
    end
    distinct  = 0;
    fixed_pts = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (!seen[sweep_out[i]]) distinct++;
      seen[sweep_out[i]] = 1'b1;
      if (sweep_out[i] == 8'(i) || sweep_out[i] == ~8'(i)) fixed_pts++;
    end
    total++;
    assert (distinct === 256) passed++;
    else $error("FAIL bijective observed=%0d expected=256", distinct);
    total++;
    assert (fixed_pts === 0) passed++;
    else $error("FAIL fixed_point_free observed=%0d expected=0", fixed_pts);

    in = 8'h01;
    tick();
    chk("hold_load", out, 8'h7C);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in = (i % 2 == 0) ? 8'hAA : 8'hxx;
      tick();
      chk("hold_out", out, 8'h7C);
      chk("hold_vld", {7'b0, out_valid}, 8'h00);
    end

    exp_out = 8'h7C;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      in_valid = v;
      in       = v ? d : 8'hxx;
      tick();
      if (v) exp_out = ref_sbox(d);
      exp_vld = v;
      chk("rand_out", out, exp_out);
      chk("rand_vld", {7'b0, out_valid}, {7'b0, exp_vld});
    end

    in_valid = 1'b1;
    in       = 8'hC9;
    tick();
    chk("pre_rst_out", out, 8'hDD);
    in = 8'h7F;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_vld", {7'b0, out_valid}, 8'h00);
    tick();
    chk("rst_hold_out", out, 8'h00);
    chk("rst_hold_vld", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    in    = 8'h10;
    tick();
    chk("resume_out", out, 8'hCA);
    chk("resume_vld", {7'b0, out_valid}, 8'h01);
    in = 8'hFF;
    tick();
    chk("resume_out2", out, 8'h16);
    in_valid = 1'b0;
    tick();
    chk("resume_idle_vld", {7'b0, out_valid}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
